iir_out_buffer: RTL and testbench

- Downstream stage of the IIR filter. Captures each valid filter output (dout/vout pulse) into a small FIFO.
- Re-presents samples to the consumer (data sink or next processing stage) over a valid/ready handshake.
- Decouples the filter's no-backpressure output from a consumer that may stall.
- Reports fill level, full/empty and a sticky overflow flag.

---
 rtl/iir_pkg.sv | 18 +
 rtl/iir_fifo_mem.sv | 27 ++
 rtl/iir_out_buffer.sv | 144 ++++++++++++++
 tb/tb_iir_out_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared IIR definitions: sample width, sample type, drop-counter width and a
// saturating increment helper used by the output buffer.
package iir_pkg;

  localparam int unsigned DATA_W     = 9;
  localparam int unsigned DROP_CNT_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (v == {DROP_CNT_W{1'b1}}) begin
      return v;
    end
    return v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/iir_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port. No reset; contents are meaningless until written.
module iir_fifo_mem #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming sample at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iir_out_buffer.sv
// Output buffer behind the IIR filter. Captures every valid filter sample into
// a small FIFO and re-presents it over a valid/ready handshake, so a stalling
// consumer cannot lose data until the FIFO is full. Reports level, full/empty
// and a sticky overflow flag.
// Optional build macro IIR_OUT_BUF_DROPCNT_EN adds a saturating 16-bit
// drop_cnt output counting discarded samples.
module iir_out_buffer #(
  parameter int unsigned DATA_W = iir_pkg::DATA_W,
  parameter int unsigned DEPTH  = 8,  // power of two, >= 2
  parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_W-1:0]               din,
  input  logic                            vin,
  input  logic                            clr,
  input  logic                            rdy,
  output logic [DATA_W-1:0]               dout,
  output logic                            vout,
  output logic [LVL_W-1:0]                level,
  output logic                            full,
  output logic                            empty,
  output logic                            ovf
`ifdef IIR_OUT_BUF_DROPCNT_EN
  ,
  output logic [iir_pkg::DROP_CNT_W-1:0]  drop_cnt
`endif
);

  import iir_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop;
  logic [DATA_W-1:0] rd_data;

  // Flags decode from the registered level only; pointer equality is never
  // used, since it is ambiguous between full and empty.
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign vout  = ~empty;
  assign ovf   = ovf_q;

  // Head sample is forced to zero while empty so reset shows dout=0 even
  // though the array itself is never reset.
  assign dout = empty ? '0 : rd_data;

  // Handshake decode. clr suppresses everything in its cycle, including the
  // drop accounting for the sample on din.
  always_comb begin
    pop  = ~empty & rdy & ~clr;
    push = vin & (~full | pop) & ~clr;
    drop = vin & full & ~pop & ~clr;
  end

  // Next-state for pointers, level and overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef IIR_OUT_BUF_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Drop counter next-state: flush wins, otherwise saturating count of drops.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = '0;
    end else if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  iir_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed bench for iir_out_buffer: reset, pass-through, fill/overflow,
// full push+pop, flush, and a randomized run against a queue scoreboard.
module tb_iir_out_buffer;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] din;
  logic              vin;
  logic              clr;
  logic              rdy;
  logic [DATA_W-1:0] dout;
  logic              vout;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              empty;
  logic              ovf;
`ifdef IIR_OUT_BUF_DROPCNT_EN
  logic [15:0]       drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] pt_vals [4];

  iir_out_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .vin      (vin),
    .clr      (clr),
    .rdy      (rdy),
    .dout     (dout),
    .vout     (vout),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf)
`ifdef IIR_OUT_BUF_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_vals[0] = 9'h0FF;
    pt_vals[1] = 9'h100;
    pt_vals[2] = 9'h1FF;
    pt_vals[3] = 9'h001;
    din = '0; vin = 0; clr = 0; rdy = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    check("rst_vout",  32'(vout),  32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_ovf",   32'(ovf),   32'd0);
    check("rst_dout",  32'(dout),  32'd0);
`ifdef IIR_OUT_BUF_DROPCNT_EN
    check("rst_dropcnt", 32'(drop_cnt), 32'd0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // Pass-through, back-to-back with rdy held high
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      vin = 1; din = pt_vals[i];
      check("pt_pre_vout_nobypass", 32'(vout), (i == 0) ? 32'd0 : 32'd1);
      step();
      check("pt_vout",  32'(vout),  32'd1);
      check("pt_dout",  32'(dout),  32'(pt_vals[i]));
      check("pt_level", 32'(level), 32'd1);
    end
    vin = 0;
    step();
    check("pt_end_vout",  32'(vout),  32'd0);
    check("pt_end_level", 32'(level), 32'd0);

    // Fill and overflow: 10 pushes into an 8-deep FIFO with consumer stalled
    rdy = 0;
    for (int i = 1; i <= 10; i++) begin
      vin = 1; din = DATA_W'(i);
      step();
      check("fill_dout_hold", 32'(dout), 32'd1);
      if (i == 7) check("fill_full7", 32'(full), 32'd0);
      if (i == 8) begin
        check("fill_full8",  32'(full),  32'd1);
        check("fill_level8", 32'(level), 32'd8);
        check("fill_ovf8",   32'(ovf),   32'd0);
      end
      if (i == 9) check("fill_ovf9", 32'(ovf), 32'd1);
    end
    vin = 0;
    check("fill_level_end", 32'(level), 32'd8);
`ifdef IIR_OUT_BUF_DROPCNT_EN
    check("fill_dropcnt", 32'(drop_cnt), 32'd2);
`endif
    rdy = 1;
    for (int k = 1; k <= 8; k++) begin
      check("drain_vout", 32'(vout), 32'd1);
      check("drain_dout", 32'(dout), 32'(k));
      step();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_vout0", 32'(vout),  32'd0);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-stream
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      vin = 1; din = DATA_W'(9'h020 + i);
      step();
    end
    vin = 0;
    check("mid_level_pre", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vout",  32'(vout),  32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_dout",  32'(dout),  32'd0);
    check("mid_rst_ovf",   32'(ovf),   32'd0);
    step();
    rst_n = 1'b1;
    vin = 1; din = 9'h0AA;
    #1;
    check("mid_post_nobypass", 32'(vout), 32'd0);
    step();
    vin = 0;
    check("mid_post_vout", 32'(vout), 32'd1);
    check("mid_post_dout", 32'(dout), 32'h0AA);
    rdy = 1;
    step();
    check("mid_post_empty", 32'(empty), 32'd1);

    // Full with simultaneous push and pop
    rdy = 0;
    for (int i = 1; i <= 8; i++) begin
      vin = 1; din = DATA_W'(9'h010 + i);
      step();
    end
    check("fs_full", 32'(full), 32'd1);
    vin = 1; din = 9'h055; rdy = 1;
    step();
    vin = 0; rdy = 0;
    check("fs_level", 32'(level), 32'd8);
    check("fs_ovf",   32'(ovf),   32'd0);
`ifdef IIR_OUT_BUF_DROPCNT_EN
    check("fs_dropcnt", 32'(drop_cnt), 32'd0);
`endif
    rdy = 1;
    for (int k = 2; k <= 8; k++) begin
      check("fs_drain", 32'(dout), 32'(9'h010 + k));
      step();
    end
    check("fs_last", 32'(dout), 32'h055);
    step();
    check("fs_empty", 32'(empty), 32'd1);

    // Flush with level 5 and ovf set, vin active during clr
    rdy = 0;
    for (int i = 1; i <= 9; i++) begin
      vin = 1; din = DATA_W'(9'h030 + i);
      step();
    end
    vin = 0; rdy = 1;
    for (int i = 0; i < 3; i++) step();
    rdy = 0;
    check("fl_level5", 32'(level), 32'd5);
    check("fl_ovf1",   32'(ovf),   32'd1);
    clr = 1; vin = 1; din = 9'h1EE;
    step();
    clr = 0; vin = 0;
    check("fl_level", 32'(level), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_ovf",   32'(ovf),   32'd0);
    check("fl_vout",  32'(vout),  32'd0);
`ifdef IIR_OUT_BUF_DROPCNT_EN
    check("fl_dropcnt", 32'(drop_cnt), 32'd0);
`endif
    rdy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_output", 32'(vout), 32'd0);
    end

    // Random traffic against a queue scoreboard
    sb.delete();
    for (int c = 0; c < 200; c++) begin
      logic pop_m;
      logic push_m;
      vin = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      din = DATA_W'($urandom);
      #1;
      check("rnd_level", 32'(level), 32'(sb.size()));
      check("rnd_vout",  32'(vout),  (sb.size() != 0) ? 32'd1 : 32'd0);
      pop_m  = (sb.size() != 0) && rdy;
      push_m = vin && ((sb.size() < DEPTH) || pop_m);
      if (pop_m) begin
        check("rnd_dout", 32'(dout), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (push_m) sb.push_back(din);
      step();
    end
    vin = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
